// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host-to-keyboard command sequencer.
// Sends a command byte and an optional argument byte through a byte-level
// transmit engine. Each byte is ACKed (0xFA) by the keyboard, or it is
// retried on resend (0xFE), on response timeout, or on a line-level
// transmit failure. Received bytes that are not consumed as a response are
// forwarded to the scan-code path one cycle later.
module ps2_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3,
  parameter int TW             = 20
) (
  input  logic       iCLK,
  input  logic       Reset,
  input  logic       cmd_start,
  input  logic [7:0] cmd_code,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] resp_byte,
  output logic [1:0] retry_cnt,
  output logic       tx_req,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       tx_fail,
  input  logic       rx_valid,
  input  logic [7:0] rx_code,
  output logic       scan_valid,
  output logic [7:0] scan_code
);

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, WAIT_CMD, SEND_ARG, WAIT_ARG, FINISH, FAIL
  } state_t;

  localparam logic [7:0]    KBD_ACK    = 8'hFA;
  localparam logic [7:0]    KBD_RESEND = 8'hFE;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX  = 2'(MAX_RETRY);

  state_t        state_q, state_d;
  logic [7:0]    arg_q, arg_d;
  logic          has_arg_q, has_arg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [7:0]    resp_q, resp_d;
  logic [1:0]    retry_q, retry_d;
  logic          tx_req_q, tx_req_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          scan_valid_q, scan_valid_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic [TW-1:0] timer_q, timer_d;

  logic in_wait;
  logic is_resp;
  logic retry_take;

  // Next-state, datapath and forwarding decisions.
  always_comb begin
    state_d      = state_q;
    arg_d        = arg_q;
    has_arg_d    = has_arg_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    resp_d       = resp_q;
    retry_d      = retry_q;
    tx_req_d     = tx_req_q;
    tx_data_d    = tx_data_q;
    timer_d      = timer_q;
    scan_valid_d = 1'b0;
    scan_code_d  = scan_code_q;
    retry_take   = 1'b0;

    in_wait = (state_q == WAIT_CMD) || (state_q == WAIT_ARG);
    is_resp = rx_valid && ((rx_code == KBD_ACK) || (rx_code == KBD_RESEND));

    // Only a response byte seen while waiting for one is swallowed; every
    // other received byte, including 0xFA/0xFE outside a wait, is scan data.
    if (rx_valid && !(in_wait && is_resp)) begin
      scan_valid_d = 1'b1;
      scan_code_d  = rx_code;
    end

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          arg_d     = cmd_arg;
          has_arg_d = cmd_has_arg;
          error_d   = 1'b0;
          retry_d   = 2'd0;
          busy_d    = 1'b1;
          tx_req_d  = 1'b1;
          tx_data_d = cmd_code;
          state_d   = SEND_CMD;
        end
      end

      SEND_CMD, SEND_ARG: begin
        // A low tx_req here means the previous attempt failed at line level;
        // re-present the same byte so the engine sees a fresh request.
        if (!tx_req_q) begin
          tx_req_d = 1'b1;
        end else if (tx_fail) begin
          tx_req_d   = 1'b0;
          retry_take = 1'b1;
        end else if (tx_done) begin
          tx_req_d = 1'b0;
          timer_d  = '0;
          state_d  = (state_q == SEND_CMD) ? WAIT_CMD : WAIT_ARG;
        end
      end

      WAIT_CMD, WAIT_ARG: begin
        timer_d = timer_q + TW'(1);
        // ACK is checked before the timeout so a same-cycle ACK wins.
        if (rx_valid && (rx_code == KBD_ACK)) begin
          resp_d  = KBD_ACK;
          retry_d = 2'd0;
          if ((state_q == WAIT_CMD) && has_arg_q) begin
            tx_req_d  = 1'b1;
            tx_data_d = arg_q;
            state_d   = SEND_ARG;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FINISH;
          end
        end else if (rx_valid && (rx_code == KBD_RESEND)) begin
          resp_d     = KBD_RESEND;
          retry_take = 1'b1;
        end else if (timer_q == TMO_LAST) begin
          retry_take = 1'b1;
        end
      end

      FINISH, FAIL: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Retries resend the byte currently held in tx_data; an argument resend
    // never goes back to the command byte.
    if (retry_take) begin
      if (retry_q < RETRY_MAX) begin
        retry_d  = retry_q + 2'd1;
        tx_req_d = in_wait;
        state_d  = ((state_q == SEND_CMD) || (state_q == WAIT_CMD)) ? SEND_CMD : SEND_ARG;
      end else begin
        tx_req_d = 1'b0;
        busy_d   = 1'b0;
        error_d  = 1'b1;
        state_d  = FAIL;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge iCLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      arg_q        <= 8'h00;
      has_arg_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      resp_q       <= 8'h00;
      retry_q      <= 2'd0;
      tx_req_q     <= 1'b0;
      tx_data_q    <= 8'h00;
      timer_q      <= '0;
      scan_valid_q <= 1'b0;
      scan_code_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      arg_q        <= arg_d;
      has_arg_q    <= has_arg_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      resp_q       <= resp_d;
      retry_q      <= retry_d;
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
      timer_q      <= timer_d;
      scan_valid_q <= scan_valid_d;
      scan_code_q  <= scan_code_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign resp_byte  = resp_q;
  assign retry_cnt  = retry_q;
  assign tx_req     = tx_req_q;
  assign tx_data    = tx_data_q;
  assign scan_valid = scan_valid_q;
  assign scan_code  = scan_code_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Bench for ps2_cmd_sequencer: directed keyboard scenarios, a transaction-level
// reference model compared every cycle, plus literal per-scenario expectations.
module tb_ps2_cmd_sequencer;

  localparam int TO   = 100;
  localparam int MAXR = 3;

  logic       iCLK = 1'b0;
  logic       Reset;
  logic       cmd_start, cmd_has_arg, tx_done, tx_fail, rx_valid;
  logic [7:0] cmd_code, cmd_arg, rx_code;
  logic       busy, done, error, tx_req, scan_valid;
  logic [7:0] resp_byte, tx_data, scan_code;
  logic [1:0] retry_cnt;

  ps2_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR), .TW(20)) dut (
    .iCLK(iCLK), .Reset(Reset),
    .cmd_start(cmd_start), .cmd_code(cmd_code), .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
    .busy(busy), .done(done), .error(error), .resp_byte(resp_byte), .retry_cnt(retry_cnt),
    .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done), .tx_fail(tx_fail),
    .rx_valid(rx_valid), .rx_code(rx_code), .scan_valid(scan_valid), .scan_code(scan_code)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: command as a list of bytes ----------------
  localparam int P_IDLE = 0, P_TX = 1, P_RX = 2, P_OK = 3, P_BAD = 4;
  int         m_ph, m_age, m_idx, m_nb;
  logic [7:0] m_bytes [2];
  logic       m_busy, m_done, m_err, m_rq, m_sv;
  logic [7:0] m_resp, m_td, m_sc;
  logic [1:0] m_rty;

  always @(posedge iCLK or negedge Reset) begin : model
    int ph, age, idx, nb;
    logic busy_n, done_n, err_n, rq_n, fwd, again;
    logic [7:0] resp_n, td_n, b0, b1;
    logic [1:0] rty_n;
    if (!Reset) begin
      m_ph <= P_IDLE; m_age <= 0; m_idx <= 0; m_nb <= 1;
      m_busy <= 0; m_done <= 0; m_err <= 0; m_rq <= 0; m_sv <= 0;
      m_resp <= 0; m_td <= 0; m_sc <= 0; m_rty <= 0;
    end else begin
      ph = m_ph; age = m_age; idx = m_idx; nb = m_nb;
      busy_n = m_busy; done_n = 0; err_n = m_err; rq_n = m_rq;
      resp_n = m_resp; td_n = m_td; rty_n = m_rty; again = 0;
      b0 = m_bytes[0]; b1 = m_bytes[1];
      fwd = rx_valid && !(m_ph == P_RX && (rx_code == 8'hFA || rx_code == 8'hFE));
      case (m_ph)
        P_IDLE: if (cmd_start) begin
          b0 = cmd_code; b1 = cmd_arg; nb = cmd_has_arg ? 2 : 1; idx = 0;
          err_n = 0; rty_n = 0; busy_n = 1; ph = P_TX; rq_n = 1; td_n = cmd_code;
        end
        P_TX: begin
          if (!m_rq) rq_n = 1;
          else if (tx_fail) begin rq_n = 0; again = 1; end
          else if (tx_done) begin rq_n = 0; ph = P_RX; age = 0; end
        end
        P_RX: begin
          if (rx_valid && rx_code == 8'hFA) begin
            resp_n = 8'hFA; rty_n = 0; idx = idx + 1;
            if (idx < nb) begin ph = P_TX; rq_n = 1; td_n = (idx == 1) ? b1 : b0; end
            else begin ph = P_OK; done_n = 1; busy_n = 0; end
          end else if (rx_valid && rx_code == 8'hFE) begin
            resp_n = 8'hFE; again = 1;
          end else if (m_age == TO - 1) again = 1;
          else age = m_age + 1;
        end
        default: ph = P_IDLE;
      endcase
      if (again) begin
        if (int'(m_rty) < MAXR) begin rty_n = m_rty + 2'd1; ph = P_TX; rq_n = (m_ph == P_RX); end
        else begin ph = P_BAD; err_n = 1; busy_n = 0; rq_n = 0; end
      end
      m_bytes[0] <= b0; m_bytes[1] <= b1;
      m_ph <= ph; m_age <= age; m_idx <= idx; m_nb <= nb;
      m_busy <= busy_n; m_done <= done_n; m_err <= err_n; m_rq <= rq_n;
      m_resp <= resp_n; m_td <= td_n; m_rty <= rty_n;
      m_sv <= fwd; m_sc <= fwd ? rx_code : m_sc;
    end
  end

  // ---------------- per-cycle compare against model ----------------
  logic cmp_en = 1'b0;
  always @(negedge iCLK) if (cmp_en) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("resp_byte", resp_byte, m_resp);
    chk("retry_cnt", retry_cnt, m_rty);
    chk("tx_req", tx_req, m_rq);
    if (m_rq) chk("tx_data", tx_data, m_td);
    chk("scan_valid", scan_valid, m_sv);
    if (m_sv) chk("scan_code", scan_code, m_sc);
  end

  // ---------------- event logs for literal checks ----------------
  logic [7:0] tx_log [64];
  logic [7:0] sc_log [64];
  int tx_n = 0, sc_n = 0, done_n = 0;
  logic prev_req = 1'b0;
  always @(negedge iCLK) begin
    prev_req <= tx_req;
    if (tx_req && !prev_req) begin tx_log[tx_n % 64] <= tx_data; tx_n <= tx_n + 1; end
    if (scan_valid) begin sc_log[sc_n % 64] <= scan_code; sc_n <= sc_n + 1; end
    if (done) done_n <= done_n + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge iCLK); #1; end
  endtask

  task automatic start(input logic [7:0] c, input logic [7:0] a, input logic h);
    cmd_start = 1; cmd_code = c; cmd_arg = a; cmd_has_arg = h;
    cyc(); cmd_start = 0;
  endtask

  task automatic wait_req(input int bound);
    int i;
    for (i = 0; i < bound && !tx_req; i++) cyc();
    if (!tx_req) chk("wait_tx_req_timeout", 0, 1);
  endtask

  task automatic send_ok();
    wait_req(250); cyc(); tx_done = 1; cyc(); tx_done = 0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_valid = 1; rx_code = b; cyc(); rx_valid = 0;
  endtask

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound && busy; i++) cyc();
    if (busy) chk("wait_idle_timeout", 0, 1);
    cyc(2);
  endtask

  int t0, s0, d0;
  task automatic snap(); t0 = tx_n; s0 = sc_n; d0 = done_n; endtask

  initial begin
    Reset = 0; cmd_start = 0; cmd_code = 0; cmd_arg = 0; cmd_has_arg = 0;
    tx_done = 0; tx_fail = 0; rx_valid = 0; rx_code = 0;
    cyc(); cmp_en = 1; cyc(2);
    chk("rst_busy", busy, 0); chk("rst_tx_req", tx_req, 0); chk("rst_tx_data", tx_data, 0);
    chk("rst_scan_valid", scan_valid, 0); chk("rst_error", error, 0);
    Reset = 1; cyc(2);

    // T1: set LEDs with argument
    snap(); start(8'hED, 8'h02, 1);
    chk("t1_busy", busy, 1); chk("t1_txd0", tx_data, 8'hED);
    send_ok(); rx(8'hFA); send_ok(); rx(8'hFA); wait_idle(20);
    chk("t1_ntx", tx_n - t0, 2); chk("t1_b0", tx_log[t0 % 64], 8'hED);
    chk("t1_b1", tx_log[(t0 + 1) % 64], 8'h02); chk("t1_done", done_n - d0, 1);
    chk("t1_error", error, 0); chk("t1_nscan", sc_n - s0, 0);

    // T2: resend then ACK
    snap(); start(8'hF4, 8'h00, 0);
    send_ok(); rx(8'hFE); send_ok();
    chk("t2_retry1", retry_cnt, 1);
    rx(8'hFA); wait_idle(20);
    chk("t2_ntx", tx_n - t0, 2); chk("t2_b1", tx_log[(t0 + 1) % 64], 8'hF4);
    chk("t2_resp", resp_byte, 8'hFA); chk("t2_done", done_n - d0, 1);

    // T3: no responses at all -> exhaust retries
    snap(); start(8'hFF, 8'h00, 0);
    repeat (1 + MAXR) send_ok();
    wait_idle(300);
    chk("t3_ntx", tx_n - t0, 4); chk("t3_error", error, 1);
    chk("t3_busy", busy, 0); chk("t3_done", done_n - d0, 0);
    snap(); start(8'hF4, 8'h00, 0);
    chk("t3_err_clr", error, 0);
    send_ok(); rx(8'hFA); wait_idle(20);
    chk("t3_done2", done_n - d0, 1);

    // T4: byte alongside tx_done is scan data; scan code interleaved in wait
    snap(); start(8'hED, 8'h55, 1);
    wait_req(10); cyc(); tx_done = 1; rx_valid = 1; rx_code = 8'hFA; cyc();
    tx_done = 0; rx_valid = 0;
    rx(8'h1C); rx(8'hFA); wait_req(10);
    chk("t4_argtx", tx_data, 8'h55);
    chk("t4_nscan", sc_n - s0, 2); chk("t4_sc0", sc_log[s0 % 64], 8'hFA);
    chk("t4_sc1", sc_log[(s0 + 1) % 64], 8'h1C);
    send_ok(); rx(8'hFA); wait_idle(20);
    chk("t4_done", done_n - d0, 1);

    // T5: tx_done+tx_fail together on the argument; fail wins, arg resent only
    snap(); start(8'hED, 8'h07, 1);
    send_ok(); rx(8'hFA); wait_req(10); cyc();
    tx_done = 1; tx_fail = 1; cyc(); tx_done = 0; tx_fail = 0;
    chk("t5_retry", retry_cnt, 1);
    send_ok(); rx(8'hFA); wait_idle(20);
    chk("t5_ntx", tx_n - t0, 3); chk("t5_b0", tx_log[t0 % 64], 8'hED);
    chk("t5_b2", tx_log[(t0 + 2) % 64], 8'h07); chk("t5_done", done_n - d0, 1);

    // T6: ACK on the exact timeout cycle wins
    snap(); start(8'hF3, 8'h00, 0);
    send_ok(); cyc(TO - 1); rx(8'hFA); wait_idle(20);
    chk("t6_ntx", tx_n - t0, 1); chk("t6_done", done_n - d0, 1); chk("t6_err", error, 0);

    // T7: cmd_start ignored while busy, then async reset in WAIT_ARG
    snap(); start(8'hED, 8'h02, 1);
    send_ok(); start(8'h11, 8'h33, 0);
    chk("t7_txd_hold", tx_data, 8'hED);
    rx(8'hFA); wait_req(10);
    chk("t7_arg_kept", tx_data, 8'h02);
    send_ok(); cyc(3); #2;
    Reset = 0; #1;
    chk("t7_busy", busy, 0); chk("t7_tx_req", tx_req, 0); chk("t7_tx_data", tx_data, 0);
    chk("t7_resp", resp_byte, 0); chk("t7_retry", retry_cnt, 0); chk("t7_error", error, 0);
    cyc(3); Reset = 1; cyc(5);
    chk("t7_done", done_n - d0, 0); chk("t7_err_after", error, 0);
    chk("t7_ntx", tx_n - t0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "global time limit");
  end

endmodule
